spi_transfer_ctrl: RTL and testbench



---
 rtl/spi_transfer_ctrl_if.sv | 41 ++++
 rtl/spi_transfer_ctrl.sv | 149 ++++++++++++++
 tb/tb_spi_transfer_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_transfer_ctrl_if.sv
// Request, response and SPI-side signal bundle for spi_transfer_ctrl.
// The slave modport is the controller's view; master is the requester/SPI side.
interface spi_transfer_ctrl_if #(
    parameter int SIZE     = 40,
    parameter int CS_SIZE  = 1,
    parameter int CNT_SIZE = 16
);
    localparam int CS_W = (CS_SIZE > 1) ? $clog2(CS_SIZE) : 1;

    logic                req_valid_in;
    logic                req_ready_out;
    logic                req_write_in;
    logic [6:0]          req_addr_in;
    logic [SIZE-9:0]     req_data_in;
    logic [CS_W-1:0]     req_cs_in;
    logic [CNT_SIZE-1:0] frame_cycles_in;
    logic [CNT_SIZE-1:0] gap_cycles_in;
    logic [SIZE-1:0]     spi_data_out;
    logic                spi_send_enable_out;
    logic [CS_W-1:0]     spi_cs_select_out;
    logic [SIZE-1:0]     spi_data_in;
    logic                resp_valid_out;
    logic                resp_ready_in;
    logic [7:0]          resp_status_out;
    logic [SIZE-9:0]     resp_data_out;
    logic                busy_out;

    modport slave (
        input  req_valid_in, req_write_in, req_addr_in, req_data_in, req_cs_in,
        input  frame_cycles_in, gap_cycles_in, spi_data_in, resp_ready_in,
        output req_ready_out, spi_data_out, spi_send_enable_out, spi_cs_select_out,
        output resp_valid_out, resp_status_out, resp_data_out, busy_out
    );

    modport master (
        output req_valid_in, req_write_in, req_addr_in, req_data_in, req_cs_in,
        output frame_cycles_in, gap_cycles_in, spi_data_in, resp_ready_in,
        input  req_ready_out, spi_data_out, spi_send_enable_out, spi_cs_select_out,
        input  resp_valid_out, resp_status_out, resp_data_out, busy_out
    );
endinterface

// File: rtl/spi_transfer_ctrl.sv
// Sequences one SPI datagram per request: timed send-enable pulse, gap, capture, response.
// Optional macro SPI_CTRL_READ_REPEAT_EN: reads are sent twice and only the second capture is returned.
module spi_transfer_ctrl #(
    parameter int SIZE     = 40,
    parameter int CS_SIZE  = 1,
    parameter int CNT_SIZE = 16
) (
    input logic               clk_in,
    input logic               reset_in,
    spi_transfer_ctrl_if.slave bus
);
    localparam int CS_W = (CS_SIZE > 1) ? $clog2(CS_SIZE) : 1;
    localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);

`ifdef SPI_CTRL_READ_REPEAT_EN
    typedef enum logic [2:0] {IDLE, FRAME, GAP, RESP, REPEAT} state_t;
`else
    typedef enum logic [2:0] {IDLE, FRAME, GAP, RESP} state_t;
`endif

    state_t              r_state;
    state_t              w_nextState;
    logic [CNT_SIZE-1:0] r_cnt;
    logic [CNT_SIZE-1:0] w_cntNext;
    logic [CNT_SIZE-1:0] r_frameLen;
    logic [CNT_SIZE-1:0] r_gapLen;
    logic [CNT_SIZE-1:0] w_frameLenIn;
    logic [CNT_SIZE-1:0] w_gapLenIn;
    logic [SIZE-1:0]     r_data;
    logic [CS_W-1:0]     r_cs;
    logic                r_enable;
    logic [7:0]          r_status;
    logic [SIZE-9:0]     r_respData;
    logic                w_accept;
    logic                w_capture;
`ifdef SPI_CTRL_READ_REPEAT_EN
    logic                r_write;
    logic                r_second;
`endif

    // A zero count would otherwise underflow the down-counter, so it is clamped to one.
    assign w_frameLenIn = (bus.frame_cycles_in == '0) ? CNT_ONE : bus.frame_cycles_in;
    assign w_gapLenIn   = (bus.gap_cycles_in == '0) ? CNT_ONE : bus.gap_cycles_in;
    assign w_accept     = (r_state == IDLE) && bus.req_valid_in;

    always_comb begin
        w_nextState = r_state;
        w_cntNext   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = FRAME;
                    w_cntNext   = w_frameLenIn - CNT_ONE;
                end
            end
            FRAME: begin
                if (r_cnt == '0) begin
                    w_nextState = GAP;
                    w_cntNext   = r_gapLen - CNT_ONE;
                end else begin
                    w_cntNext = r_cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
`ifdef SPI_CTRL_READ_REPEAT_EN
                    // The first read pass only primes the slave; its capture is discarded.
                    if (!r_write && !r_second) begin
                        w_nextState = REPEAT;
                    end else begin
                        w_nextState = RESP;
                        w_capture   = 1'b1;
                    end
`else
                    w_nextState = RESP;
                    w_capture   = 1'b1;
`endif
                end else begin
                    w_cntNext = r_cnt - CNT_ONE;
                end
            end
`ifdef SPI_CTRL_READ_REPEAT_EN
            REPEAT: begin
                w_nextState = FRAME;
                w_cntNext   = r_frameLen - CNT_ONE;
            end
`endif
            RESP: begin
                if (bus.resp_ready_in) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Enable is registered from the next state so it changes exactly on state boundaries.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_frameLen <= CNT_ONE;
            r_gapLen   <= CNT_ONE;
            r_data     <= '0;
            r_cs       <= '0;
            r_enable   <= 1'b0;
            r_status   <= '0;
            r_respData <= '0;
`ifdef SPI_CTRL_READ_REPEAT_EN
            r_write    <= 1'b0;
            r_second   <= 1'b0;
`endif
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_cntNext;
            r_enable <= (w_nextState == FRAME);
            if (w_accept) begin
                r_data     <= {bus.req_write_in, bus.req_addr_in,
                               (bus.req_write_in ? bus.req_data_in : '0)};
                r_cs       <= bus.req_cs_in;
                r_frameLen <= w_frameLenIn;
                r_gapLen   <= w_gapLenIn;
`ifdef SPI_CTRL_READ_REPEAT_EN
                r_write    <= bus.req_write_in;
                r_second   <= 1'b0;
`endif
            end
`ifdef SPI_CTRL_READ_REPEAT_EN
            if (r_state == REPEAT) begin
                r_second <= 1'b1;
            end
`endif
            if (w_capture) begin
                r_status   <= bus.spi_data_in[SIZE-1:SIZE-8];
                r_respData <= bus.spi_data_in[SIZE-9:0];
            end
        end
    end

    assign bus.req_ready_out       = (r_state == IDLE);
    assign bus.busy_out            = (r_state != IDLE);
    assign bus.resp_valid_out      = (r_state == RESP);
    assign bus.spi_send_enable_out = r_enable;
    assign bus.spi_data_out        = r_data;
    assign bus.spi_cs_select_out   = r_cs;
    assign bus.resp_status_out     = r_status;
    assign bus.resp_data_out       = r_respData;
endmodule

// File: tb/tb_spi_transfer_ctrl.sv
// Randomized and directed bench for spi_transfer_ctrl against a cycle-list reference model.
// Honours SPI_CTRL_READ_REPEAT_EN the same way as the design build.
module tb_spi_transfer_ctrl;
    localparam int SIZE     = 40;
    localparam int CS_SIZE  = 4;
    localparam int CNT_SIZE = 16;

    logic clk_in   = 1'b0;
    logic reset_in = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

    spi_transfer_ctrl_if #(.SIZE(SIZE), .CS_SIZE(CS_SIZE), .CNT_SIZE(CNT_SIZE)) bus ();

    spi_transfer_ctrl #(.SIZE(SIZE), .CS_SIZE(CS_SIZE), .CNT_SIZE(CNT_SIZE)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs that must be ignored while busy get fresh random values every cycle.
    task automatic scramble();
        bus.req_valid_in    = 1'($urandom);
        bus.req_write_in    = 1'($urandom);
        bus.req_addr_in     = 7'($urandom);
        bus.req_data_in     = $urandom;
        bus.req_cs_in       = 2'($urandom);
        bus.frame_cycles_in = 16'($urandom);
        bus.gap_cycles_in   = 16'($urandom);
        bus.spi_data_in     = {8'($urandom), $urandom};
    endtask

    task automatic applyStimulus(input bit wr, input logic [6:0] addr, input logic [31:0] data,
                                 input logic [1:0] cs, input int fr, input int gp, input int hold);
        bit          enPlan[$];
        int          f;
        int          g;
        int          last;
        logic [39:0] expFrame;
        logic [39:0] capVal;
        f = (fr == 0) ? 1 : fr;
        g = (gp == 0) ? 1 : gp;
        // Enable plan for cycles 1..N after the handshake cycle; response appears at N+1.
        for (int i = 0; i < f; i++) enPlan.push_back(1'b1);
        for (int i = 0; i < g; i++) enPlan.push_back(1'b0);
`ifdef SPI_CTRL_READ_REPEAT_EN
        if (!wr) begin
            enPlan.push_back(1'b0);
            for (int i = 0; i < f; i++) enPlan.push_back(1'b1);
            for (int i = 0; i < g; i++) enPlan.push_back(1'b0);
        end
`endif
        last     = enPlan.size() + 1;
        expFrame = {wr, addr, (wr ? data : 32'h0)};
        capVal   = '0;

        bus.req_valid_in    = 1'b1;
        bus.req_write_in    = wr;
        bus.req_addr_in     = addr;
        bus.req_data_in     = data;
        bus.req_cs_in       = cs;
        bus.frame_cycles_in = 16'(fr);
        bus.gap_cycles_in   = 16'(gp);
        bus.resp_ready_in   = 1'b0;
        checkOutput("ready_idle", 64'(bus.req_ready_out), 64'd1);
        checkOutput("busy_idle", 64'(bus.busy_out), 64'd0);
        tick();

        for (int c = 1; c <= last; c++) begin
            scramble();
            bus.resp_ready_in = (c < last) ? 1'($urandom) : 1'b0;
            if (c == last - 1) capVal = bus.spi_data_in;
            checkOutput("enable", 64'(bus.spi_send_enable_out), 64'((c < last) ? enPlan[c-1] : 1'b0));
            checkOutput("resp_valid", 64'(bus.resp_valid_out), 64'(c == last));
            checkOutput("busy", 64'(bus.busy_out), 64'd1);
            checkOutput("ready_busy", 64'(bus.req_ready_out), 64'd0);
            checkOutput("spi_data", 64'(bus.spi_data_out), 64'(expFrame));
            checkOutput("spi_cs", 64'(bus.spi_cs_select_out), 64'(cs));
            if (c < last) tick();
        end
        checkOutput("resp_status", 64'(bus.resp_status_out), 64'(capVal[39:32]));
        checkOutput("resp_data", 64'(bus.resp_data_out), 64'(capVal[31:0]));

        for (int h = 0; h < hold; h++) begin
            tick();
            scramble();
            bus.resp_ready_in = 1'b0;
            checkOutput("hold_valid", 64'(bus.resp_valid_out), 64'd1);
            checkOutput("hold_ready", 64'(bus.req_ready_out), 64'd0);
            checkOutput("hold_enable", 64'(bus.spi_send_enable_out), 64'd0);
            checkOutput("hold_status", 64'(bus.resp_status_out), 64'(capVal[39:32]));
            checkOutput("hold_data", 64'(bus.resp_data_out), 64'(capVal[31:0]));
            checkOutput("hold_spi_data", 64'(bus.spi_data_out), 64'(expFrame));
        end

        bus.resp_ready_in = 1'b1;
        tick();
        bus.resp_ready_in = 1'b0;
        bus.req_valid_in  = 1'b0;
        checkOutput("done_busy", 64'(bus.busy_out), 64'd0);
        checkOutput("done_ready", 64'(bus.req_ready_out), 64'd1);
        checkOutput("done_valid", 64'(bus.resp_valid_out), 64'd0);
    endtask

    initial begin
        bus.req_valid_in    = 1'b0;
        bus.req_write_in    = 1'b0;
        bus.req_addr_in     = '0;
        bus.req_data_in     = '0;
        bus.req_cs_in       = '0;
        bus.frame_cycles_in = '0;
        bus.gap_cycles_in   = '0;
        bus.spi_data_in     = '0;
        bus.resp_ready_in   = 1'b0;
        reset_in            = 1'b1;
        tick();
        tick();
        checkOutput("rst_ready", 64'(bus.req_ready_out), 64'd1);
        checkOutput("rst_busy", 64'(bus.busy_out), 64'd0);
        checkOutput("rst_enable", 64'(bus.spi_send_enable_out), 64'd0);
        checkOutput("rst_valid", 64'(bus.resp_valid_out), 64'd0);
        checkOutput("rst_spi_data", 64'(bus.spi_data_out), 64'd0);
        checkOutput("rst_cs", 64'(bus.spi_cs_select_out), 64'd0);
        checkOutput("rst_status", 64'(bus.resp_status_out), 64'd0);
        checkOutput("rst_resp_data", 64'(bus.resp_data_out), 64'd0);
        reset_in = 1'b0;
        tick();

        $display("[TB] directed write 0x6C frame=100 gap=10");
        applyStimulus(1'b1, 7'h6C, 32'h00010203, 2'd2, 100, 10, 0);
        $display("[TB] directed read 0x01");
        applyStimulus(1'b0, 7'h01, 32'hDEADBEEF, 2'd1, 5, 3, 2);
        $display("[TB] zero frame and gap counts");
        applyStimulus(1'b1, 7'h15, 32'hA5A5A5A5, 2'd3, 0, 0, 0);
        $display("[TB] response held for 50 cycles");
        applyStimulus(1'b0, 7'h7F, 32'h0, 2'd0, 2, 1, 50);

        $display("[TB] reset in the middle of a frame");
        bus.req_valid_in    = 1'b1;
        bus.req_write_in    = 1'b1;
        bus.req_addr_in     = 7'h22;
        bus.req_data_in     = 32'h11223344;
        bus.req_cs_in       = 2'd3;
        bus.frame_cycles_in = 16'd100;
        bus.gap_cycles_in   = 16'd10;
        tick();
        bus.req_valid_in = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            checkOutput("mid_enable", 64'(bus.spi_send_enable_out), 64'd1);
            if (c == 40) reset_in = 1'b1;
            tick();
        end
        reset_in = 1'b0;
        checkOutput("mid_rst_enable", 64'(bus.spi_send_enable_out), 64'd0);
        checkOutput("mid_rst_ready", 64'(bus.req_ready_out), 64'd1);
        checkOutput("mid_rst_busy", 64'(bus.busy_out), 64'd0);
        checkOutput("mid_rst_spi_data", 64'(bus.spi_data_out), 64'd0);
        for (int c = 0; c < 120; c++) begin
            checkOutput("mid_no_resp", 64'(bus.resp_valid_out), 64'd0);
            checkOutput("mid_no_enable", 64'(bus.spi_send_enable_out), 64'd0);
            tick();
        end

        $display("[TB] randomized requests");
        for (int t = 0; t < 30; t++) begin
            applyStimulus(1'($urandom), 7'($urandom), $urandom, 2'($urandom),
                          int'($urandom_range(0, 20)), int'($urandom_range(0, 8)),
                          int'($urandom_range(0, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
